// File: rtl/sc_stream_sng_pkg.sv
// Shared constants, FSM state type and index/operand helpers for the
// bit-serial stochastic number generator.
package sc_stream_sng_pkg;

  localparam int STREAM_LENGTH      = 32;
  localparam int LOG_LEN            = 5;
  localparam int SOBOL_VALID_BITWTH = LOG_LEN + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Van der Corput order: reversing the index bits spreads the ones evenly.
  function automatic logic [LOG_LEN-1:0] bitrev(input logic [LOG_LEN-1:0] v);
    logic [LOG_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < LOG_LEN; i++) begin
      r[i] = v[LOG_LEN-1-i];
    end
    return r;
  endfunction

  function automatic logic [SOBOL_VALID_BITWTH-1:0] clamp_op(
      input logic [SOBOL_VALID_BITWTH-1:0] v);
    logic [SOBOL_VALID_BITWTH-1:0] lim;
    lim = SOBOL_VALID_BITWTH'(STREAM_LENGTH);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sc_stream_sng_if.sv
// Operand-in / stream-out handshake bundle. The master drives operands and
// out_ready; the slave (the generator) drives in_ready and the beat fields.
interface sc_stream_sng_if;
  import sc_stream_sng_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [SOBOL_VALID_BITWTH-1:0] a_in;
  logic [SOBOL_VALID_BITWTH-1:0] b_in;
  logic                          out_valid;
  logic                          out_ready;
  logic                          a_bit;
  logic                          b_bit;
  logic                          and_bit;
  logic                          out_last;
  logic [LOG_LEN-1:0]            beat_idx;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, a_bit, b_bit, and_bit, out_last, beat_idx
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, a_bit, b_bit, and_bit, out_last, beat_idx
  );

endinterface

// File: rtl/sc_lds_cmp.sv
// Combinational low-discrepancy comparator: stream A uses the bit-reversed
// index, stream B the plain ramp, and_bit is their SC product.
module sc_lds_cmp
  import sc_stream_sng_pkg::*;
(
  input  logic [LOG_LEN-1:0]            idx_i,
  input  logic [SOBOL_VALID_BITWTH-1:0] a_i,
  input  logic [SOBOL_VALID_BITWTH-1:0] b_i,
  output logic                          a_bit_o,
  output logic                          b_bit_o,
  output logic                          and_bit_o
);

  logic [SOBOL_VALID_BITWTH-1:0] idx_rev_ext;
  logic [SOBOL_VALID_BITWTH-1:0] idx_ext;

  assign idx_rev_ext = {1'b0, bitrev(idx_i)};
  assign idx_ext     = {1'b0, idx_i};

  assign a_bit_o   = (a_i > idx_rev_ext);
  assign b_bit_o   = (b_i > idx_ext);
  assign and_bit_o = a_bit_o & b_bit_o;

endmodule

// File: rtl/sc_stream_sng.sv
// Serial SNG: accepts an operand pair, then emits STREAM_LENGTH beats of
// two stochastic bitstreams plus their AND under valid/ready flow control.
module sc_stream_sng
  import sc_stream_sng_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sc_stream_sng_if.slave bus
);

  state_e                        state_q, state_d;
  logic [LOG_LEN-1:0]            idx_q, idx_d;
  logic [SOBOL_VALID_BITWTH-1:0] a_q, a_d;
  logic [SOBOL_VALID_BITWTH-1:0] b_q, b_d;

  logic streaming;
  logic last_beat;
  logic a_raw, b_raw, and_raw;

  assign streaming = (state_q == STREAM);
  assign last_beat = streaming && (idx_q == LOG_LEN'(STREAM_LENGTH - 1));

  sc_lds_cmp u_cmp (
    .idx_i     (idx_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .a_bit_o   (a_raw),
    .b_bit_o   (b_raw),
    .and_bit_o (and_raw)
  );

  // Operands stay registered after a stream, so gate the beat bits in IDLE.
  assign bus.out_valid = streaming;
  assign bus.out_last  = last_beat;
  assign bus.beat_idx  = idx_q;
  assign bus.a_bit     = streaming & a_raw;
  assign bus.b_bit     = streaming & b_raw;
  assign bus.and_bit   = streaming & and_raw;
  assign bus.in_ready  = !streaming || (last_beat && bus.out_ready);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = clamp_op(bus.a_in);
          b_d     = clamp_op(bus.b_in);
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (last_beat) begin
            idx_d = '0;
            // A waiting pair chains straight into the next stream.
            if (bus.in_valid) begin
              a_d = clamp_op(bus.a_in);
              b_d = clamp_op(bus.b_in);
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_sc_stream_sng.sv
// Directed bench for sc_stream_sng: drives at posedge+1, samples at negedge,
// checks bit counts, framing, stalls, back-to-back chaining and reset abort.
module tb_sc_stream_sng;
  import sc_stream_sng_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sc_stream_sng_if bus ();

  sc_stream_sng dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [5:0] a, input logic [5:0] b);
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    @(negedge clk);
    chk({tag, "_accept_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_accept_novalid"}, 32'(bus.out_valid), 0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 1);
    tick();
  endtask

  // Collects one 32-beat stream; optionally stalls and/or presents the next pair.
  task automatic run_stream(input string tag, input int stall_idx, input int stall_n,
                            input bit b2b, input logic [5:0] nxt_a, input logic [5:0] nxt_b,
                            input bit pat16, input int ea, input int eb, input int eand);
    int na = 0, nb = 0, nn = 0, nlast = 0, lastpos = -1;
    int beats = 0, cyc = 0, err = 0, stall_left = stall_n, stall_seen = 0;
    logic sa = 1'b0, sb = 1'b0;
    bit first = 1'b1;
    while (beats < 32 && cyc < 200) begin
      cyc++;
      bus.out_ready = !(beats == stall_idx && stall_left > 0);
      if (b2b) begin
        bus.in_valid = 1'b1;
        if (beats == 31) begin
          bus.a_in = nxt_a;
          bus.b_in = nxt_b;
        end
      end
      @(negedge clk);
      if (first) begin
        chk({tag, "_first_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_first_idx"}, 32'(bus.beat_idx), 0);
        first = 1'b0;
      end
      if (bus.out_valid !== 1'b1 || bus.beat_idx !== beats[4:0]) err++;
      if (bus.and_bit !== (bus.a_bit & bus.b_bit)) err++;
      if (bus.out_last !== (beats == 31)) err++;
      if (bus.in_ready !== ((beats == 31) && bus.out_ready)) err++;
      if (pat16 && (bus.a_bit !== ~beats[0] || bus.b_bit !== (beats < 16))) err++;
      if (bus.out_ready) begin
        na += int'(bus.a_bit);
        nb += int'(bus.b_bit);
        nn += int'(bus.and_bit);
        if (bus.out_last) begin
          nlast++;
          lastpos = beats;
        end
        beats++;
      end else begin
        if (stall_seen == 0) begin
          sa = bus.a_bit;
          sb = bus.b_bit;
        end else if (bus.a_bit !== sa || bus.b_bit !== sb) begin
          err++;
        end
        stall_seen++;
        stall_left--;
      end
      tick();
    end
    bus.out_ready = 1'b1;
    chk({tag, "_beats"}, 32'(beats), 32);
    chk({tag, "_a_count"}, 32'(na), 32'(ea));
    chk({tag, "_b_count"}, 32'(nb), 32'(eb));
    chk({tag, "_and_count"}, 32'(nn), 32'(eand));
    chk({tag, "_last_count"}, 32'(nlast), 1);
    chk({tag, "_last_pos"}, 32'(lastpos), 31);
    chk({tag, "_beat_errors"}, 32'(err), 0);
    chk({tag, "_stall_cycles"}, 32'(stall_seen), 32'(stall_n));
    $display("stream %s: beats=%0d ones a=%0d b=%0d and=%0d stalls=%0d",
             tag, beats, na, nb, nn, stall_seen);
  endtask

  initial begin
    int c;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_ready", 32'(bus.in_ready), 1);
    chk("reset_last", 32'(bus.out_last), 0);
    chk("reset_idx", 32'(bus.beat_idx), 0);
    chk("reset_bits", 32'({bus.a_bit, bus.b_bit, bus.and_bit}), 0);
    tick();
    rst = 1'b0;
    tick();

    accept("a16b16", 6'd16, 6'd16);
    run_stream("a16b16", -1, 0, 1'b0, 6'd0, 6'd0, 1'b1, 16, 16, 8);
    post_idle("a16b16");

    accept("a32b32", 6'd32, 6'd32);
    run_stream("a32b32", -1, 0, 1'b0, 6'd0, 6'd0, 1'b0, 32, 32, 32);
    post_idle("a32b32");

    accept("a0b20", 6'd0, 6'd20);
    run_stream("a0b20", -1, 0, 1'b0, 6'd0, 6'd0, 1'b0, 0, 20, 0);
    post_idle("a0b20");

    accept("clamp", 6'd40, 6'd63);
    run_stream("clamp", -1, 0, 1'b0, 6'd0, 6'd0, 1'b0, 32, 32, 32);
    post_idle("clamp");

    accept("stall", 6'd8, 6'd24);
    run_stream("stall", 5, 3, 1'b0, 6'd0, 6'd0, 1'b0, 8, 24, 6);
    post_idle("stall");

    accept("b2b1", 6'd5, 6'd7);
    run_stream("b2b1", -1, 0, 1'b1, 6'd9, 6'd3, 1'b0, 5, 7, 2);
    bus.in_valid = 1'b0;
    run_stream("b2b2", -1, 0, 1'b0, 6'd0, 6'd0, 1'b0, 9, 3, 2);
    post_idle("b2b2");

    accept("abort", 6'd20, 6'd20);
    c = 0;
    while (bus.beat_idx != 5'd10 && c < 100) begin
      tick();
      c++;
    end
    chk("abort_reach_idx10", 32'(bus.beat_idx), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_ready", 32'(bus.in_ready), 1);
    chk("abort_idx", 32'(bus.beat_idx), 0);
    chk("abort_last", 32'(bus.out_last), 0);
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("abort_stays_idle", 32'(bus.out_valid), 0);
      tick();
    end
    $display("stream abort: reset applied at beat 10");

    accept("a4b4", 6'd4, 6'd4);
    run_stream("a4b4", -1, 0, 1'b0, 6'd0, 6'd0, 1'b0, 4, 4, 1);
    post_idle("a4b4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
